// File: rtl/axis_pkt_gen.sv
// AXI-stream frame source: sends pkt_count frames of pkt_len bytes carrying a
// seeded incrementing byte pattern, honouring tready backpressure.
module axis_pkt_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [CNT_WIDTH-1:0]  pkt_count,
  input  logic [7:0]            seed,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frame_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [LEN_WIDTH-1:0] KW_L = LEN_WIDTH'(KEEP_WIDTH);
  localparam logic [7:0]           KW_B = 8'(KEEP_WIDTH);

  logic [1:0]           state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] rem_q;   // bytes left in the frame, counting the beat on the bus
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [7:0]           frame_base;
  logic [7:0]           beat_base;

  logic                 hs;
  logic                 last_frame;
  logic                 load_beat;
  logic                 clear_beat;
  logic [7:0]           nxt_base;
  logic [LEN_WIDTH-1:0] nxt_rem;

  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [7:0] b,
                                                      input logic [LEN_WIDTH-1:0] r);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (LEN_WIDTH'(i) < r) d[i*8 +: 8] = b + 8'(i);
    end
    return d;
  endfunction

  function automatic logic [KEEP_WIDTH-1:0] beat_keep(input logic [LEN_WIDTH-1:0] r);
    logic [KEEP_WIDTH-1:0] k;
    k = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      k[i] = (LEN_WIDTH'(i) < r);
    end
    return k;
  endfunction

  // Handshake rules: a beat transfers on a cycle where tvalid && tready; while
  // tvalid is high and tready low, tdata/tkeep/tlast are held and tvalid stays high.
  assign hs         = m_axis_tvalid && m_axis_tready;
  assign last_frame = (frame_cnt == cnt_q - CNT_WIDTH'(1));

  always_comb begin
    nxt_base   = beat_base + KW_B;
    nxt_rem    = rem_q - KW_L;
    load_beat  = 1'b0;
    clear_beat = 1'b0;
    if (state == S_IDLE) begin
      nxt_base  = seed;
      nxt_rem   = pkt_len;
      load_beat = start && (pkt_len != '0) && (pkt_count != '0);
    end else if (state == S_SEND) begin
      if (m_axis_tlast) begin
        nxt_base = frame_base + 8'd1;
        nxt_rem  = len_q;
      end
      load_beat  = hs && !(m_axis_tlast && last_frame);
      clear_beat = hs && m_axis_tlast && last_frame;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_beat) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      beat_base     <= '0;
      rem_q         <= '0;
    end else if (load_beat) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= beat_data(nxt_base, nxt_rem);
      m_axis_tkeep  <= beat_keep(nxt_rem);
      m_axis_tlast  <= (nxt_rem <= KW_L);
      beat_base     <= nxt_base;
      rem_q         <= nxt_rem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_cnt  <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      frame_base <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q      <= pkt_len;
            cnt_q      <= pkt_count;
            frame_base <= seed;
            frame_cnt  <= '0;
            busy       <= 1'b1;
            state      <= load_beat ? S_SEND : S_FIN;
          end
        end
        S_SEND: begin
          if (hs && m_axis_tlast) begin
            frame_cnt <= frame_cnt + CNT_WIDTH'(1);
            if (last_frame) begin
              state <= S_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              frame_base <= nxt_base;
            end
          end
        end
        S_FIN: begin
          // An empty run enters FIN with done low and spends one extra cycle here.
          if (done) begin
            done  <= 1'b0;
            state <= S_IDLE;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed and randomized runs of axis_pkt_gen checked beat-by-beat against a
// byte-offset model of the frame pattern.
module tb_axis_pkt_gen;

  localparam int DW = 64;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   pkt_len;
  logic [15:0]   pkt_count;
  logic [7:0]    seed;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;
  logic [15:0]   frame_cnt;

  logic [DW+KW:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  bit pat [0:5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  axis_pkt_gen dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .pkt_len       (pkt_len),
    .pkt_count     (pkt_count),
    .seed          (seed),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .frame_cnt     (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Expected beats as {tdata, tkeep, tlast}, built from byte offsets within each frame.
  task automatic model(input int sd, input int len, input int cnt);
    int nb;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    nb = (len + KW - 1) / KW;
    for (int f = 0; f < cnt; f++) begin
      for (int b = 0; b < nb; b++) begin
        d = '0;
        k = '0;
        for (int i = 0; i < KW; i++) begin
          if (b * KW + i < len) begin
            d[i*8 +: 8] = 8'((sd + f + b * KW + i) % 256);
            k[i] = 1'b1;
          end
        end
        exp_q.push_back({d, k, (b == nb - 1)});
      end
    end
  endtask

  // mode 0: tready always 1; mode 1: random tready; mode 2: fixed 1,0,0,1,0,1 pattern.
  task automatic run(input logic [7:0] sd, input int len, input int cnt, input int mode,
                     input bit restart);
    logic [DW-1:0]  pd;
    logic [KW-1:0]  pk;
    logic           pl;
    logic [DW+KW:0] e;
    bit stalled, fin, rdy;
    int cyc, nbeats;
    exp_q.delete();
    model(sd, len, cnt);
    nbeats = exp_q.size();
    seed = sd;
    pkt_len = len[15:0];
    pkt_count = cnt[15:0];
    m_axis_tready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (nbeats == 0) begin
      check("empty_tvalid_t1", m_axis_tvalid, 0);
      check("empty_done_t1", done, 0);
      step();
      check("empty_done_t2", done, 1);
      check("empty_busy_t2", busy, 0);
      check("empty_tvalid_t2", m_axis_tvalid, 0);
      check("empty_frame_cnt", frame_cnt, 0);
      step();
      check("empty_done_clear", done, 0);
      return;
    end
    stalled = 0;
    fin = 0;
    cyc = 0;
    pd = '0;
    pk = '0;
    pl = 1'b0;
    while (!fin && cyc < 20000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 9) < 7);
        default: rdy = pat[cyc % 6];
      endcase
      m_axis_tready = rdy;
      if (restart) begin
        start = (cyc == 1);
        pkt_len = (cyc == 1) ? 16'd3 : len[15:0];
        seed = (cyc == 1) ? ~sd : sd;
      end
      check("tvalid_high", m_axis_tvalid, 1);
      check("busy_high", busy, 1);
      if (stalled) begin
        check("hold_tdata", m_axis_tdata, pd);
        check("hold_tkeep", m_axis_tkeep, pk);
        check("hold_tlast", m_axis_tlast, pl);
      end
      if (rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
          fin = 1;
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_axis_tdata, e[DW+KW:KW+1]);
          check("tkeep", m_axis_tkeep, e[KW:1]);
          check("tlast", m_axis_tlast, e[0]);
          if (exp_q.size() == 0) fin = 1;
        end
        stalled = 0;
      end else begin
        stalled = 1;
        pd = m_axis_tdata;
        pk = m_axis_tkeep;
        pl = m_axis_tlast;
      end
      step();
      cyc++;
    end
    m_axis_tready = 1'b0;
    start = 1'b0;
    if (!fin) check("run_timeout", 0, 1);
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("tvalid_at_done", m_axis_tvalid, 0);
    check("frame_cnt_end", frame_cnt, 64'(cnt % 65536));
    if (mode == 0) check("busy_cycles", cyc, nbeats);
    step();
    check("done_one_cycle", done, 0);
    check("frame_cnt_hold", frame_cnt, 64'(cnt % 65536));
  endtask

  initial begin
    logic [DW+KW:0] e;
    rst = 1'b1;
    start = 1'b0;
    pkt_len = '0;
    pkt_count = '0;
    seed = '0;
    m_axis_tready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep", m_axis_tkeep, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    step();

    run(8'h00, 16, 1, 0, 0);
    run(8'h00, 13, 1, 0, 0);
    run(8'($urandom_range(0, 255)), 24, 1, 2, 0);
    run(8'hFE, 8, 3, 0, 0);
    run(8'h00, 0, 5, 0, 0);
    run(8'h11, 5, 0, 0, 0);
    run(8'($urandom_range(0, 255)), 20 + $urandom_range(0, 20), 2, 1, 1);
    for (int n = 0; n < 6; n++) begin
      run(8'($urandom), $urandom_range(1, 70), $urandom_range(1, 4), 1, 0);
    end

    // Reset while beat 2 of a 4-beat frame is stalled.
    exp_q.delete();
    model(8'h40, 32, 1);
    seed = 8'h40;
    pkt_len = 16'd32;
    pkt_count = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    m_axis_tready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      e = exp_q.pop_front();
      check("pre_rst_tdata", m_axis_tdata, e[DW+KW:KW+1]);
      step();
    end
    m_axis_tready = 1'b0;
    e = exp_q.pop_front();
    check("pre_rst_beat2", m_axis_tdata, e[DW+KW:KW+1]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_tvalid", m_axis_tvalid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    check("mid_rst_tdata", m_axis_tdata, 0);
    step();
    run(8'h40, 32, 1, 1, 0);

    run(8'h5A, 65535, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
